ipu_sequencer: RTL and testbench

IPU_SEQUENCER -- requirements
Module: ipu_sequencer

---
 rtl/ipu_sequencer.sv | 155 +++++++++++++++
 tb/tb_ipu_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ipu_sequencer.sv
// ipu_sequencer: polls an IPU control register, drains received bytes and
// pushes queued bytes through the IPU data registers with a bounded send wait.
module ipu_sequencer #(
  parameter int unsigned TX_TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        tx_done,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        err_timeout,
  output logic        wr_o,
  output logic        reg_sel_o,
  output logic        addr_o,
  output logic [31:0] entrada_o,
  input  logic [31:0] salida_i
);

  typedef enum logic [2:0] {
    IDLE, CHK, RX_RD, RX_CAP, RX_CLR, TX_DATA, TX_CMD, TX_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        tx_done_q, tx_done_d;
  logic        rx_valid_q, rx_valid_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        wr_q, wr_d;
  logic        reg_sel_q, reg_sel_d;
  logic        addr_q, addr_d;
  logic [31:0] entrada_q, entrada_d;
  logic        tx_turn_q, tx_turn_d;
  logic [15:0] cnt_q, cnt_d;
  logic        accept;
  logic        unused_salida;

  assign unused_salida = ^salida_i[31:8];

  always_comb begin
    state_d    = state_q;
    tx_byte_d  = tx_byte_q;
    rx_data_d  = rx_data_q;
    tx_done_d  = 1'b0;
    rx_valid_d = 1'b0;
    err_d      = err_q;
    tx_turn_d  = tx_turn_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;

    case (state_q)
      IDLE: state_d = CHK;
      CHK: begin
        // A pending tx_turn lets a waiting send overtake a re-raised new_rx.
        if (tx_valid && (tx_turn_q || !salida_i[1])) begin
          accept    = 1'b1;
          tx_byte_d = tx_data;
          err_d     = 1'b0;
          tx_turn_d = 1'b0;
          state_d   = TX_DATA;
        end else if (salida_i[1]) begin
          state_d = RX_RD;
        end else begin
          state_d = IDLE;
        end
      end
      RX_RD:  state_d = RX_CAP;
      RX_CAP: begin
        rx_data_d  = salida_i[7:0];
        rx_valid_d = 1'b1;
        state_d    = RX_CLR;
      end
      RX_CLR: begin
        if (tx_valid) tx_turn_d = 1'b1;
        state_d = IDLE;
      end
      TX_DATA: state_d = TX_CMD;
      TX_CMD: begin
        cnt_d   = '0;
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // cnt_q == 0 marks the first wait cycle, whose read predates the send command.
        if ((cnt_q != '0) && !salida_i[0]) begin
          tx_done_d = 1'b1;
          state_d   = IDLE;
        end else if ({16'h0, cnt_d} >= TX_TIMEOUT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_d      = (state_d == TX_DATA) || (state_d == TX_CMD) || (state_d == RX_CLR);
    reg_sel_d = (state_d == TX_DATA) || (state_d == RX_RD);
    addr_d    = (state_d == RX_RD);
    busy_d    = !((state_d == IDLE) || (state_d == CHK));
    entrada_d = '0;
    if (state_d == TX_DATA)     entrada_d = {24'h0, tx_byte_d};
    else if (state_d == TX_CMD) entrada_d = 32'h1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rx_data_q  <= '0;
      tx_done_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_q       <= 1'b0;
      reg_sel_q  <= 1'b0;
      addr_q     <= 1'b0;
      entrada_q  <= '0;
      tx_turn_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rx_data_q  <= rx_data_d;
      tx_done_q  <= tx_done_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      wr_q       <= wr_d;
      reg_sel_q  <= reg_sel_d;
      addr_q     <= addr_d;
      entrada_q  <= entrada_d;
      tx_turn_q  <= tx_turn_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_byte_q <= tx_byte_d;
  end

  assign tx_ready    = accept;
  assign tx_done     = tx_done_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign wr_o        = wr_q;
  assign reg_sel_o   = reg_sel_q;
  assign addr_o      = addr_q;
  assign entrada_o   = entrada_q;

endmodule

// File: tb/tb_ipu_sequencer.sv
// Scoreboard bench for ipu_sequencer: an IPU register model feeds the main
// instance; a second instance with a never-completing IPU exercises timeout.
module tb_ipu_sequencer;

  localparam int CLR_DELAY = 100;
  localparam logic [2:0] K_READY = 3'd0, K_WDATA = 3'd1, K_WCTRL = 3'd2,
                         K_DONE  = 3'd3, K_RXV   = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        tx_valid, tx_ready, tx_done, rx_valid, busy, err_timeout;
  logic        wr_o, reg_sel_o, addr_o;
  logic [7:0]  tx_data, rx_data;
  logic [31:0] entrada_o;
  logic [31:0] salida = 32'h0;

  logic        tx_valid2, tx_ready2, tx_done2, rx_valid2, busy2, err2;
  logic        wr2, reg_sel2, addr2;
  logic [7:0]  tx_data2, rx_data2;
  logic [31:0] entrada2;

  ipu_sequencer dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .err_timeout(err_timeout),
    .wr_o(wr_o), .reg_sel_o(reg_sel_o), .addr_o(addr_o),
    .entrada_o(entrada_o), .salida_i(salida)
  );

  ipu_sequencer #(.TX_TIMEOUT(50)) dut_to (
    .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_data(tx_data2),
    .tx_ready(tx_ready2), .tx_done(tx_done2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .busy(busy2), .err_timeout(err2),
    .wr_o(wr2), .reg_sel_o(reg_sel2), .addr_o(addr2),
    .entrada_o(entrada2), .salida_i(32'h1)
  );

  // IPU register model: one-cycle registered read, send bit auto-clears.
  logic [1:0] ctrl = 2'b00;
  logic [7:0] txreg = 8'h00;
  logic [7:0] rxreg = 8'h00;
  int         clr_cnt = 0;
  int         rx_clears = 0;
  int         rx_target = 0;
  logic       set_rx = 1'b0;

  always @(posedge clk) begin
    salida <= reg_sel_o ? (addr_o ? {24'h0, rxreg} : {24'h0, txreg}) : {30'h0, ctrl};
    if (wr_o && reg_sel_o && !addr_o) txreg <= entrada_o[7:0];
    if (wr_o && !reg_sel_o) begin
      ctrl[0] <= entrada_o[0];
      if (entrada_o[0]) clr_cnt <= CLR_DELAY;
      if (entrada_o == 32'h0) begin
        rx_clears <= rx_clears + 1;
        ctrl[1]   <= (rx_clears + 1 < rx_target);
      end
    end else if (clr_cnt > 0) begin
      clr_cnt <= clr_cnt - 1;
      if (clr_cnt == 1) ctrl[0] <= 1'b0;
    end
    if (set_rx) ctrl[1] <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [2:0] kind, input logic [31:0] data);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d data %h, required none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.data !== data) begin
        miscompares++;
        $display("FAIL event: got kind %0d data %h, required kind %0d data %h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every DUT-visible transaction is checked against the scoreboard.
  int cyc = 0;
  int ready_cyc = -10;
  int wr_viol = 0;
  int done2_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (!wr_o && entrada_o != 32'h0) wr_viol++;
    if (rst && tx_done2) done2_cnt++;
    if (rst) begin
      if (tx_ready) begin
        observe(K_READY, 32'h0);
        ready_cyc = cyc;
      end
      if (wr_o && reg_sel_o && !addr_o) begin
        observe(K_WDATA, entrada_o);
        chk("wdata_latency", cyc, ready_cyc + 1);
      end
      if (rx_valid) observe(K_RXV, {24'h0, rx_data});
      if (wr_o && !reg_sel_o) begin
        observe(K_WCTRL, entrada_o);
        if (entrada_o == 32'h1) chk("cmd_latency", cyc, ready_cyc + 2);
      end
      if (tx_done) observe(K_DONE, 32'h0);
    end
  end

  task automatic drain(input int bound, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_ready(input bit second, input int bound, input string name);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      got = second ? tx_ready2 : tx_ready;
    end
    chk(name, {31'h0, got}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_ready"}, {31'h0, tx_ready}, 32'h0);
    chk({tag, "_tx_done"}, {31'h0, tx_done}, 32'h0);
    chk({tag, "_rx_data"}, {24'h0, rx_data}, 32'h0);
    chk({tag, "_rx_valid"}, {31'h0, rx_valid}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_err"}, {31'h0, err_timeout}, 32'h0);
    chk({tag, "_wr"}, {31'h0, wr_o}, 32'h0);
    chk({tag, "_reg_sel"}, {31'h0, reg_sel_o}, 32'h0);
    chk({tag, "_addr"}, {31'h0, addr_o}, 32'h0);
    chk({tag, "_entrada"}, entrada_o, 32'h0);
  endtask

  initial begin
    tx_valid = 1'b0; tx_data = 8'h00; tx_valid2 = 1'b0; tx_data2 = 8'h00;
    #1 rst = 1'b0;
    #1 check_reset_outputs("por");
    chk("por_err2", {31'h0, err2}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Send 0xA5; tx_data changes after accept must not leak into the write.
    push(K_READY, 32'h0); push(K_WDATA, 32'hA5); push(K_WCTRL, 32'h1); push(K_DONE, 32'h0);
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'hA5;
    wait_ready(1'b0, 20, "send_ready");
    @(posedge clk); #1 tx_valid = 1'b0; tx_data = 8'hFF;
    drain(400, "send_drain");
    repeat (20) @(negedge clk);
    chk("send_err", {31'h0, err_timeout}, 32'h0);
    chk("send_busy", {31'h0, busy}, 32'h0);

    // Receive 0x3C.
    rxreg = 8'h3C;
    rx_target = rx_clears + 1;
    push(K_RXV, 32'h3C); push(K_WCTRL, 32'h0);
    @(posedge clk); #1 set_rx = 1'b1;
    @(posedge clk); #1 set_rx = 1'b0;
    drain(50, "rx_drain");
    repeat (30) @(negedge clk);
    chk("rx_hold", {24'h0, rx_data}, 32'h3C);

    // Contention: rx first, then tx despite new_rx re-raised, then rx again.
    rxreg = 8'h5A;
    rx_target = rx_clears + 2;
    push(K_RXV, 32'h5A); push(K_WCTRL, 32'h0);
    push(K_READY, 32'h0); push(K_WDATA, 32'h77); push(K_WCTRL, 32'h1); push(K_DONE, 32'h0);
    push(K_RXV, 32'h5A); push(K_WCTRL, 32'h0);
    @(posedge clk); #1 set_rx = 1'b1;
    @(posedge clk); #1 set_rx = 1'b0;
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h77;
    wait_ready(1'b0, 40, "cont_ready");
    @(posedge clk); #1 tx_valid = 1'b0;
    drain(400, "cont_drain");
    repeat (10) @(negedge clk);

    // Timeout on the TX_TIMEOUT=50 instance: err rises exactly 53 cycles after accept.
    @(posedge clk); #1 tx_valid2 = 1'b1; tx_data2 = 8'h11;
    wait_ready(1'b1, 20, "to_ready");
    @(posedge clk); #1 tx_valid2 = 1'b0;
    repeat (52) @(negedge clk);
    chk("to_err_before", {31'h0, err2}, 32'h0);
    chk("to_busy_before", {31'h0, busy2}, 32'h1);
    @(negedge clk);
    chk("to_err_set", {31'h0, err2}, 32'h1);
    chk("to_busy_idle", {31'h0, busy2}, 32'h0);
    chk("to_wr_idle", {31'h0, wr2}, 32'h0);
    repeat (5) @(negedge clk);
    chk("to_err_sticky", {31'h0, err2}, 32'h1);
    @(posedge clk); #1 tx_valid2 = 1'b1; tx_data2 = 8'h22;
    wait_ready(1'b1, 20, "to_ready2");
    @(posedge clk); #1 tx_valid2 = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", {31'h0, err2}, 32'h0);

    // Reset in the middle of TX_WAIT.
    push(K_READY, 32'h0); push(K_WDATA, 32'h5C); push(K_WCTRL, 32'h1);
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h5C;
    wait_ready(1'b0, 20, "rst_ready");
    @(posedge clk); #1 tx_valid = 1'b0;
    drain(20, "rst_drain");
    repeat (10) @(negedge clk);
    chk("rst_busy_before", {31'h0, busy}, 32'h1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid");
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (150) @(negedge clk);
    chk("rst_no_done", {31'h0, tx_done}, 32'h0);
    chk("rst_busy_after", {31'h0, busy}, 32'h0);

    chk("sb_empty", exp_q.size(), 32'h0);
    chk("wr_entrada_zero", wr_viol, 32'h0);
    chk("to_no_done", done2_cnt, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
